// File: rtl/alu_exec_seq_pkg.sv
// alu_exec_seq_pkg: shared opcodes, state encoding and instruction field layout.
// Rev 1.0
`default_nettype none

package alu_exec_seq_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 3;
   localparam int IW_DEF = 16;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 7;
   localparam int RS2_MSB = 6;
   localparam int RS2_LSB = 4;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   function automatic logic op_sets_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if: instruction handshake plus register-file read/write ports.
// Rev 1.0
`default_nettype none

interface alu_exec_seq_if
   import alu_exec_seq_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int IW = IW_DEF
);

   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] instr;
   logic [AW-1:0] read_add1;
   logic [AW-1:0] read_add2;
   logic [DW-1:0] read_data1;
   logic [DW-1:0] read_data2;
   logic          write_en;
   logic [AW-1:0] write_add;
   logic [DW-1:0] write_data;

   // master = instruction source plus register file; slave = the sequencer
   modport master (
      output in_valid, instr, read_data1, read_data2,
      input  in_ready, read_add1, read_add2, write_en, write_add, write_data
   );

   modport slave (
      input  in_valid, instr, read_data1, read_data2,
      output in_ready, read_add1, read_add2, write_en, write_add, write_data
   );

endinterface

`default_nettype wire

// File: rtl/alu_exec_seq_alu8.sv
// alu_exec_seq_alu8: combinational ALU producing result and carry/borrow.
// Rev 1.0
`default_nettype none

module alu_exec_seq_alu8
   import alu_exec_seq_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] imm,
   output logic [DW-1:0] res,
   output logic          c
);

   always_comb begin
      res = '0;
      c   = 1'b0;
      case (op)
         OP_ADD: {c, res} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            res = a - b;
            c   = (a < b);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_LDI: res = imm;
         OP_SHL: begin
            res = {a[DW-2:0], 1'b0};
            c   = a[DW-1];
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: four-state execute sequencer (IDLE/READ/EXEC/WB) in front of an 8x8 register file.
// Rev 1.0
`default_nettype none

module alu_exec_seq
   import alu_exec_seq_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int IW = IW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   alu_exec_seq_if.slave     bus,
   output logic              done,
   output logic              flag_z,
   output logic              flag_c,
   output logic [15:0]       retired
);

   state_t        state;
   logic          ready_q;
   logic [2:0]    op_q;
   logic [AW-1:0] rd_q;
   logic [DW-1:0] imm_q;
   logic [AW-1:0] ra1_q;
   logic [AW-1:0] ra2_q;
   logic [DW-1:0] opa_q;
   logic [DW-1:0] opb_q;
   logic          we_q;
   logic [AW-1:0] wa_q;
   logic [DW-1:0] wd_q;

   logic [IW-1:0] instr_w;
   logic [DW-1:0] alu_res;
   logic          alu_c;

   assign instr_w       = bus.instr;
   assign bus.in_ready  = ready_q;
   assign bus.read_add1 = ra1_q;
   assign bus.read_add2 = ra2_q;
   assign bus.write_en  = we_q;
   assign bus.write_add = wa_q;
   assign bus.write_data = wd_q;

   alu_exec_seq_alu8 #(.DW(DW)) u_alu (
      .op  (op_q),
      .a   (opa_q),
      .b   (opb_q),
      .imm (imm_q),
      .res (alu_res),
      .c   (alu_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         ready_q <= 1'b1;
         op_q    <= OP_NOP;
         rd_q    <= '0;
         imm_q   <= '0;
         ra1_q   <= '0;
         ra2_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         done    <= 1'b0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         retired <= '0;
      end else begin
         we_q <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_q    <= instr_w[OP_MSB:OP_LSB];
                  rd_q    <= AW'(instr_w[RD_MSB:RD_LSB]);
                  imm_q   <= DW'(instr_w[IMM_MSB:IMM_LSB]);
                  ra1_q   <= AW'(instr_w[RS1_MSB:RS1_LSB]);
                  ra2_q   <= AW'(instr_w[RS2_MSB:RS2_LSB]);
                  ready_q <= 1'b0;
                  state   <= ST_READ;
               end
            end
            ST_READ: begin
               opa_q <= bus.read_data1;
               opb_q <= bus.read_data2;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               // Outputs are registered on leaving EXEC so they are live for the whole retire slot
               done    <= 1'b1;
               retired <= retired + 16'd1;
               if (op_q == OP_NOP) begin
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  we_q   <= 1'b1;
                  wa_q   <= rd_q;
                  wd_q   <= alu_res;
                  flag_z <= (alu_res == '0);
                  if (op_sets_carry(op_q)) begin
                     flag_c <= alu_c;
                  end
                  state <= ST_WB;
               end
            end
            ST_WB: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed bench with a behavioural 8x8 register file.
// Rev 1.0
`default_nettype none

module tb_alu_exec_seq;
   import alu_exec_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        done;
   logic        flag_z;
   logic        flag_c;
   logic [15:0] retired;

   int checks = 0;
   int errors = 0;

   logic [7:0] rf [8];
   logic       pre_en   = 1'b0;
   logic [2:0] pre_addr = 3'd0;
   logic [7:0] pre_data = 8'd0;

   alu_exec_seq_if bus ();

   alu_exec_seq dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .done    (done),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .retired (retired)
   );

   always #5 clk = ~clk;

   assign bus.read_data1 = rf[bus.read_add1];
   assign bus.read_data2 = rf[bus.read_add2];

   always @(posedge clk) begin
      if (bus.write_en) rf[bus.write_add] <= bus.write_data;
      else if (pre_en)  rf[pre_addr]      <= pre_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // Issue one instruction from IDLE and check the retire slot
   task automatic run(input string tag, input logic [15:0] ins, input logic exp_we,
                      input logic [2:0] exp_wa, input logic [7:0] exp_wd,
                      input logic exp_z, input logic exp_c, input logic [15:0] exp_ret);
      int n;
      logic seen;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.instr    = ins;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.instr    = 16'($urandom);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (done) seen = 1'b1;
      end
      chk({tag, "_latency"}, 32'(n), 32'd3);
      chk({tag, "_we"},      32'(bus.write_en),   32'(exp_we));
      chk({tag, "_wa"},      32'(bus.write_add),  32'(exp_wa));
      chk({tag, "_wd"},      32'(bus.write_data), 32'(exp_wd));
      chk({tag, "_z"},       32'(flag_z),         32'(exp_z));
      chk({tag, "_c"},       32'(flag_c),         32'(exp_c));
      chk({tag, "_retired"}, 32'(retired),        32'(exp_ret));
   endtask

   initial begin
      int   n;
      logic seen;
      logic any_we;

      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.instr    = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_ready",   32'(bus.in_ready), 32'd1);
      chk("rst_we",      32'(bus.write_en), 32'd0);
      chk("rst_done",    32'(done),         32'd0);
      chk("rst_z",       32'(flag_z),       32'd0);
      chk("rst_c",       32'(flag_c),       32'd0);
      chk("rst_retired", 32'(retired),      32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(bus.in_ready), 32'd1);

      // LDI r1,7F
      run("ldi", 16'hC47F, 1'b1, 3'd1, 8'h7F, 1'b0, 1'b0, 16'd1);
      @(negedge clk);
      chk("ldi_rf", 32'(rf[1]), 32'h7F);

      preload(3'd1, 8'hF0);
      preload(3'd2, 8'h20);

      // ADD r3,r1,r2 : F0+20 = 110
      run("add", 16'h2CA0, 1'b1, 3'd3, 8'h10, 1'b0, 1'b1, 16'd2);
      // NOP : write port holds, flags unchanged
      run("nop", 16'h0000, 1'b0, 3'd3, 8'h10, 1'b0, 1'b1, 16'd3);
      // SUB r4,r2,r2
      run("sub", 16'h5120, 1'b1, 3'd4, 8'h00, 1'b1, 1'b0, 16'd4);

      // Back-to-back: XOR r5,r1,r2 then OR r6,r1,r2 with in_valid held high
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.instr    = 16'hB4A0;
      @(posedge clk);
      #1;
      bus.instr = 16'h98A0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (done) seen = 1'b1;
      end
      chk("b2b_lat",   32'(n),              32'd3);
      chk("b2b_wa1",   32'(bus.write_add),  32'd5);
      chk("b2b_wd1",   32'(bus.write_data), 32'hD0);
      chk("b2b_busy",  32'(bus.in_ready),   32'd0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (n == 2) bus.in_valid = 1'b0;
         if (done) seen = 1'b1;
      end
      chk("b2b_spacing", 32'(n),              32'd4);
      chk("b2b_wa2",     32'(bus.write_add),  32'd6);
      chk("b2b_wd2",     32'(bus.write_data), 32'hF0);
      chk("b2b_retired", 32'(retired),        32'd6);

      // SHL r7,r1 : F0<<1 = E0, carry out 1
      run("shl", 16'hFC80, 1'b1, 3'd7, 8'hE0, 1'b0, 1'b1, 16'd7);
      // AND r0,r1,r2 : carry held from SHL
      run("and", 16'h60A0, 1'b1, 3'd0, 8'h20, 1'b0, 1'b1, 16'd8);

      // ADD r7,r1,r2 aborted by reset during EXEC
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.instr    = 16'h3CA0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_we",      32'(bus.write_en),   32'd0);
      chk("abort_done",    32'(done),           32'd0);
      chk("abort_ready",   32'(bus.in_ready),   32'd1);
      chk("abort_wa",      32'(bus.write_add),  32'd0);
      chk("abort_wd",      32'(bus.write_data), 32'd0);
      chk("abort_z",       32'(flag_z),         32'd0);
      chk("abort_c",       32'(flag_c),         32'd0);
      chk("abort_retired", 32'(retired),        32'd0);
      any_we = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.write_en) any_we = 1'b1;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (bus.write_en) any_we = 1'b1;
      end
      chk("abort_no_we", 32'(any_we), 32'd0);
      chk("abort_rf7",   32'(rf[7]),  32'hE0);

      // LDI r2,00 after abort
      run("ldi0", 16'hC800, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Multi-cycle execute sequencer sitting directly upstream of the 8x8 register file.
- Accepts one 16-bit instruction per valid/ready handshake and drives the register file read addresses.
- Samples the two operands, computes an 8-bit ALU result, and issues a single-cycle write-back to the register file write port.
- Also maintains zero/carry flags and a count of retired instructions.

Parameters:
- DW, 8, data width; matches register file word width.
- AW, 3, register address width (8 registers).
- IW, 16, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  instruction present on instr.
- in_ready  out  1  block can accept an instruction.
- instr  in  IW  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm8 (LDI only).
- read_add1  out  AW  to register file read port 1 (rs1).
- read_add2  out  AW  to register file read port 2 (rs2).
- read_data1  in  DW  from register file port 1.
- read_data2  in  DW  from register file port 2.
- write_en  out  1  register file write strobe.
- write_add  out  AW  write-back register (rd).
- write_data  out  DW  write-back value.
- done  out  1  one-cycle pulse, instruction retired.
- flag_z  out  1  last result was zero.
- flag_c  out  1  carry/borrow of last ADD/SUB.
- retired  out  16  retired-instruction counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; in_ready=1.
  - write_en=0, done=0, flag_z=0, flag_c=0, retired=0.
  - read_add1/2, write_add and write_data all 0; latched instruction cleared.
- States: IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. On in_valid&in_ready at edge N, latch instr, go to READ. in_ready=0 in every other state.
  - READ (cycle N+1): read_add1=rs1, read_add2=rs2, held registered. The register file's combinational read settles within the cycle.
  - EXEC (cycle N+2): capture read_data1/2 into operand regs, compute result (DW bits) and carry, update flags.
    - NOP: no flag update; go to IDLE with done=1 next cycle, no write.
    - All other ops: go to WB.
  - WB (cycle N+3): write_en=1, write_add=rd, write_data=result, done=1, retired+=1. Then IDLE.
  - NOP retires identically: done=1 and retired+=1 in the N+3 slot, write_en=0.
- Latency: 3 cycles from accepting edge to write_en/done. Back-to-back throughput is one instruction per 4 cycles.
- Ops:
  - 000 NOP.
  - 001 ADD: {c,res}=a+b.
  - 010 SUB: res=a-b, c=borrow (a<b).
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 LDI: res=imm8; operands ignored.
  - 111 SHL: res=a<<1, c=a[7].
- Flag rules:
  - flag_z=(res==0) for all non-NOP ops.
  - flag_c updated only by ADD/SUB/SHL; held otherwise.
  - Arithmetic wraps modulo 2^DW.
- Outputs outside WB: write_en=0 and done=0. write_add/write_data hold their last value.
- in_valid while busy: ignored, no capture, instr need not be held. Upstream holds instr until the handshake.
- Read-after-write: the next instruction's READ is at least 2 edges after the WB edge, so no hazard forwarding is required. rd==rs1 is legal.
- retired wraps 16'hFFFF -> 0.
- Reset mid-operation aborts the instruction immediately: write_en drops asynchronously, no partial write, counter cleared.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP..OP_SHL);
  - state encoding (IDLE/READ/EXEC/WB);
  - instruction field bit positions;
  - DW/AW/IW defaults.
- One natural sub-module: alu8 (combinational: op, a, b, imm -> res, c).
- FSM, operand registers, flags and counter stay in alu_exec_seq.

Test Plan:
- Reset then release -> in_ready=1, write_en=0, flag_z=0, flag_c=0, retired=0.
- LDI r1,8'h7F at edge N -> write_en=1, write_add=1, write_data=8'h7F at cycle N+3; done pulse; retired=1.
- Register file pre-loaded with r1=8'hF0, r2=8'h20:
  - ADD r3,r1,r2 -> write_data=8'h10, flag_c=1, flag_z=0.
  - SUB r4,r2,r2 -> 8'h00, flag_z=1, flag_c=0.
- in_valid held high with a new instr during READ/EXEC/WB -> ignored, captured only when back in IDLE; 4-cycle spacing between done pulses.
- NOP -> done pulse, write_en stays 0, flags unchanged, retired increments.
- Assert rst during EXEC of ADD -> no write_en pulse, all outputs at reset values, next LDI executes normally.
